// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from four requesters.
// Handles inter-frame gap, WAIT_DONE timeout and deferred baud changes.
module uart_tx_arbiter #(
   parameter int          GAP_CYCLES     = 4,
   parameter int          TIMEOUT_CYCLES = 20000,
   parameter logic [1:0]  BAUD_DEFAULT   = 2'b11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  gnt,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   input  logic        tx_done,
   input  logic        cfg_load,
   input  logic [1:0]  cfg_baud,
   output logic [1:0]  baud_select,
   output logic [1:0]  active_id,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_DONE,
      GAP
   } state_t;

   localparam int CNT_MAX =
      (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST =
      CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t          state;
   logic [1:0]      ptr;
   logic [1:0]      win_q;
   logic            pending;
   logic [1:0]      pend_baud;
   logic [CW-1:0]   cnt;

   logic [1:0]      win;
   logic [1:0]      idx;
   logic            found;
   logic            grant_ok;

   always_comb begin
      win   = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // A cfg_load arriving this cycle blocks the grant so the new baud
   // rate is applied before the next frame starts.
   assign grant_ok = found && !tx_busy && !pending && !cfg_load;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         win_q       <= '0;
         pending     <= 1'b0;
         pend_baud   <= '0;
         cnt         <= '0;
         gnt         <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         active_id   <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         baud_select <= BAUD_DEFAULT;
      end else begin
         gnt      <= '0;
         tx_start <= 1'b0;
         busy     <= (state != IDLE);

         if (cfg_load) begin
            pending   <= 1'b1;
            pend_baud <= cfg_baud;
         end

         unique case (state)
            IDLE: begin
               if (pending) begin
                  baud_select <= pend_baud;
                  if (!cfg_load)
                     pending <= 1'b0;
               end else if (grant_ok) begin
                  win_q <= win;
                  ptr   <= win + 2'd1;
                  state <= START;
               end
            end
            START: begin
               cnt <= '0;
               if (req[win_q]) begin
                  tx_start  <= 1'b1;
                  gnt       <= 4'b0001 << win_q;
                  tx_data   <= req_data[{win_q, 3'b000} +: 8];
                  active_id <= win_q;
                  state     <= WAIT_DONE;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_DONE: begin
               if (tx_done) begin
                  cnt   <= '0;
                  state <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end else if (cnt == TO_LAST) begin
                  cnt         <= '0;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter against a
// transaction-level round-robin / timing model.
module tb_uart_tx_arbiter;

   localparam int GAP = 4;
   localparam int TO  = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        tx_done;
   logic        cfg_load;
   logic [1:0]  cfg_baud;
   logic [1:0]  baud_select;
   logic [1:0]  active_id;
   logic        busy;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;
   logic [1:0] m_baud = 2'b11;

   uart_tx_arbiter #(
      .GAP_CYCLES(GAP),
      .TIMEOUT_CYCLES(TO),
      .BAUD_DEFAULT(2'b11)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .req_data(req_data),
      .gnt(gnt),
      .tx_start(tx_start),
      .tx_data(tx_data),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .cfg_load(cfg_load),
      .cfg_baud(cfg_baud),
      .baud_select(baud_select),
      .active_id(active_id),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   task automatic wait_start(input string tag);
      int n = 0;
      while (tx_start !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      chk(tag, tx_start, 1);
   endtask

   // Called in the cycle tx_start is visible; leaves one cycle later.
   task automatic check_grant(input string tag, input logic [3:0] r);
      int w;
      logic [3:0] eg;
      logic [31:0] d;
      w  = rr_pick(r, m_ptr);
      eg = 4'b0001 << w;
      d  = req_data;
      chk({tag, "_gnt"}, gnt, eg);
      chk({tag, "_data"}, tx_data, d[8*w +: 8]);
      chk({tag, "_id"}, active_id, w);
      chk({tag, "_baud"}, baud_select, m_baud);
      m_ptr = (w + 1) % 4;
      step();
      chk({tag, "_pulse"}, {tx_start, gnt}, 0);
   endtask

   task automatic finish_frame(input string tag, input int delay);
      repeat (delay) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      repeat (GAP) step();
      chk({tag, "_busy_gap"}, busy, 1);
      step();
      chk({tag, "_busy_end"}, busy, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_outs"}, {gnt, tx_start, tx_data, active_id, busy,
                           timeout_err}, 0);
      chk({tag, "_baud"}, baud_select, 2'b11);
   endtask

   initial begin
      logic [3:0] r;
      logic [3:0] r2;
      logic [1:0] nb;
      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
      cfg_load = 1'b0;
      cfg_baud = '0;
      step();
      step();
      check_reset_vals("reset");
      reset = 1'b0;
      step();

      // single request, exact latency
      req_data = $urandom;
      req_data[23:16] = 8'hAA;
      req = 4'b0100;
      step();
      chk("single_lat0", tx_start, 0);
      step();
      chk("single_lat1", tx_start, 1);
      chk("single_tx_data", tx_data, 8'hAA);
      check_grant("single", 4'b0100);
      req = '0;
      finish_frame("single", 3);

      // reset during WAIT_DONE, late tx_done ignored
      req = 4'b0010;
      req_data = $urandom;
      wait_start("rst_start");
      check_grant("rst", 4'b0010);
      req = '0;
      repeat (3) step();
      reset = 1'b1;
      step();
      check_reset_vals("midreset");
      reset = 1'b0;
      m_ptr = 0;
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("late_done_quiet", {tx_start, gnt, busy}, 0);
         step();
      end

      // fairness: all requesting, strict rotation from ptr 0
      req = 4'b1111;
      req_data = $urandom;
      for (int g = 0; g < 5; g++) begin
         wait_start("fair_start");
         chk("fair_order", active_id, g % 4);
         check_grant("fair", 4'b1111);
         if (g == 4) req = '0;
         finish_frame("fair", 8);
      end

      // back-pressure from tx_busy
      tx_busy = 1'b1;
      req = 4'b0001;
      req_data = $urandom;
      repeat ($urandom_range(5, 15)) step();
      chk("bp_hold", {tx_start, busy}, 0);
      tx_busy = 1'b0;
      step();
      chk("bp_lat0", tx_start, 0);
      step();
      chk("bp_lat1", tx_start, 1);
      check_grant("bp", 4'b0001);
      req = '0;
      finish_frame("bp", 2);

      // requester withdraws while blocked
      tx_busy = 1'b1;
      req = 4'b1000;
      repeat (3) step();
      req = '0;
      tx_busy = 1'b0;
      repeat (6) step();
      chk("drop_nogrant", {tx_start, gnt, busy, timeout_err}, 0);

      // baud change requested mid-frame
      r = 4'($urandom_range(1, 15));
      req = r;
      req_data = $urandom;
      wait_start("cfg_start");
      check_grant("cfg", r);
      req = '0;
      step();
      cfg_load = 1'b1;
      cfg_baud = 2'b01;
      step();
      cfg_load = 1'b0;
      chk("cfg_hold_wait", baud_select, 2'b11);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      r2 = 4'($urandom_range(1, 15));
      req = r2;
      repeat (GAP) step();
      chk("cfg_hold_gap", baud_select, 2'b11);
      step();
      chk("cfg_applied", baud_select, 2'b01);
      chk("cfg_nogrant", tx_start, 0);
      m_baud = 2'b01;
      step();
      chk("cfg_lat0", tx_start, 0);
      step();
      chk("cfg_lat1", tx_start, 1);
      check_grant("cfg2", r2);
      req = '0;
      finish_frame("cfg2", 1);

      // cfg_load together with req in IDLE
      r = 4'($urandom_range(1, 15));
      nb = 2'($urandom_range(0, 3));
      req = r;
      req_data = $urandom;
      cfg_load = 1'b1;
      cfg_baud = nb;
      step();
      cfg_load = 1'b0;
      chk("same_nogrant", tx_start, 0);
      step();
      chk("same_baud", baud_select, nb);
      m_baud = nb;
      step();
      chk("same_lat0", tx_start, 0);
      step();
      chk("same_lat1", tx_start, 1);
      check_grant("same", r);
      req = '0;
      finish_frame("same", 4);

      // timeout then a normal grant
      r = 4'($urandom_range(1, 15));
      req = r;
      req_data = $urandom;
      wait_start("to_start");
      check_grant("to", r);
      r2 = 4'($urandom_range(1, 15));
      req = r2;
      repeat (TO - 2) step();
      chk("to_before", timeout_err, 0);
      step();
      chk("to_flag", timeout_err, 1);
      wait_start("to_next");
      check_grant("to_next", r2);
      req = '0;
      finish_frame("to_next", 2);
      chk("to_sticky", timeout_err, 1);

      // randomized frames
      for (int it = 0; it < 12; it++) begin
         r = 4'($urandom_range(1, 15));
         req = r;
         req_data = $urandom;
         step();
         chk("rnd_lat0", tx_start, 0);
         step();
         chk("rnd_lat1", tx_start, 1);
         check_grant("rnd", r);
         req = '0;
         finish_frame("rnd", $urandom_range(0, 8));
      end

      reset = 1'b1;
      step();
      check_reset_vals("final_reset");
      reset = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
